// File: rtl/fpu_op_sched_pkg.sv
// Shared types and constants for the two-port FP operation scheduler.
// Holds op codes, operand class codes, the canonical quiet NaN and FSM encoding.
package fpu_op_sched_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } fp_cls_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLASSIFY = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  // Denormals classify as NORM so they reach the datapath.
  function automatic fp_cls_e fp_class(input logic [31:0] x);
    fp_cls_e c;
    if (x[30:23] == 8'hFF)
      c = (x[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    else if (x[30:0] == 31'd0)
      c = CLS_ZERO;
    else
      c = CLS_NORM;
    return c;
  endfunction

endpackage

// File: rtl/fpu_op_sched_special.sv
// Combinational IEEE-754 special-case resolver for add/mul.
// Flags operand pairs that never need the shared datapath.
module fpu_special_case
  import fpu_op_sched_pkg::*;
(
  input  logic        i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_special,
  output logic [31:0] o_result
);

  fp_cls_e w_ca;
  fp_cls_e w_cb;
  logic    w_sa;
  logic    w_sb;
  logic    w_nan;
  logic    w_inf;
  logic    w_zero;

  assign w_ca   = fp_class(i_a);
  assign w_cb   = fp_class(i_b);
  assign w_sa   = i_a[31];
  assign w_sb   = i_b[31];
  assign w_nan  = (w_ca == CLS_NAN) || (w_cb == CLS_NAN);
  assign w_inf  = (w_ca == CLS_INF) || (w_cb == CLS_INF);
  assign w_zero = (w_ca == CLS_ZERO) || (w_cb == CLS_ZERO);

  always_comb begin
    o_special = 1'b1;
    o_result  = QNAN;
    if (w_nan) begin
      o_result = QNAN;
    end else if (i_op == OP_ADD && w_inf) begin
      if (w_ca == CLS_INF && w_cb == CLS_INF)
        o_result = (w_sa != w_sb) ? QNAN : i_a;
      else
        o_result = (w_ca == CLS_INF) ? i_a : i_b;
    end else if (i_op == OP_MUL && w_inf) begin
      o_result = w_zero ? QNAN : {w_sa ^ w_sb, 8'hFF, 23'd0};
    end else if (i_op == OP_ADD && w_zero) begin
      if (w_ca == CLS_ZERO && w_cb == CLS_ZERO)
        o_result = {w_sa & w_sb, 31'd0};
      else
        o_result = (w_ca == CLS_ZERO) ? i_b : i_a;
    end else if (i_op == OP_MUL && w_zero) begin
      o_result = {w_sa ^ w_sb, 31'd0};
    end else begin
      o_special = 1'b0;
      o_result  = 32'd0;
    end
  end

endmodule

// File: rtl/fpu_op_sched.sv
// Round-robin scheduler sharing one multi-cycle FP add/mul datapath
// between two requesters, with local special-case handling and a timeout.
module fpu_op_sched
  import fpu_op_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [63:0] i_req_a,
  input  logic [63:0] i_req_b,
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_dp_start,
  output logic        o_dp_op,
  output logic [31:0] o_dp_a,
  output logic [31:0] o_dp_b,
  input  logic        i_dp_done,
  input  logic [31:0] i_dp_result
);

  logic [2:0]       r_state;
  logic             r_grant;
  logic             r_last;
  logic             r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_data;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_win;
  logic             w_any;
  logic             w_special;
  logic [31:0]      w_sp_result;

  assign w_any = |i_req_valid;

  always_comb begin
    w_win = 1'b0;
    unique case (i_req_valid)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  fpu_special_case u_special (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_special (w_special),
    .o_result  (w_sp_result)
  );

  assign o_req_ready = (rst_n && r_state == S_IDLE && w_any)
                     ? {w_win, ~w_win} : 2'b00;
  assign o_rsp_valid = (r_state == S_RESP)
                     ? {r_grant, ~r_grant} : 2'b00;
  assign o_rsp_data  = r_data;
  assign o_rsp_err   = r_err;
  assign o_dp_start  = (r_state == S_ISSUE);
  assign o_dp_op     = r_op;
  assign o_dp_a      = r_a;
  assign o_dp_b      = r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_op    <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op    <= i_req_op[w_win];
            r_a     <= i_req_a[32*w_win +: 32];
            r_b     <= i_req_b[32*w_win +: 32];
            r_grant <= w_win;
            r_last  <= w_win;
            r_state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          if (w_special) begin
            r_data  <= w_sp_result;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (i_dp_done) begin
            r_data  <= i_dp_result;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_data  <= QNAN;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready[r_grant])
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sched.sv
// Self-checking bench for fpu_op_sched: vector table, corner sequences,
// and randomized transactions against a rule-level reference model.
module tb_fpu_op_sched;

  localparam int TO = 64;
  localparam logic [31:0] QN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        dp_start;
  logic        dp_op;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        dp_done;
  logic [31:0] dp_result;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_op_sched #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_dp_start  (dp_start),
    .o_dp_op     (dp_op),
    .o_dp_a      (dp_a),
    .o_dp_b      (dp_b),
    .i_dp_done   (dp_done),
    .i_dp_result (dp_result)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'd0;
  endfunction
  function automatic bit is_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 23'd0;
  endfunction
  function automatic bit is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // Returns {special, result}; result is don't-care when not special.
  function automatic logic [32:0] model(input bit op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return {1'b1, QN};
    if (!op) begin
      if (is_inf(a) && is_inf(b))
        return {1'b1, (a[31] != b[31]) ? QN : a};
      if (is_inf(a)) return {1'b1, a};
      if (is_inf(b)) return {1'b1, b};
      if (is_zero(a) && is_zero(b))
        return {1'b1, a[31] & b[31], 31'd0};
      if (is_zero(a)) return {1'b1, b};
      if (is_zero(b)) return {1'b1, a};
    end else begin
      if (is_inf(a) || is_inf(b))
        return (is_zero(a) || is_zero(b)) ? {1'b1, QN}
                                          : {1'b1, a[31] ^ b[31], 8'hFF, 23'd0};
      if (is_zero(a) || is_zero(b))
        return {1'b1, a[31] ^ b[31], 31'd0};
    end
    return 33'd0;
  endfunction

  function automatic logic [31:0] rand_opnd();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 5))
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 23'($urandom) | 23'd1};
      3: return {s, 8'd0, 23'($urandom) | 23'd1};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Called on a negedge in IDLE with rsp_ready high; returns on a negedge in IDLE.
  // lat < 0 means the datapath never completes.
  task automatic run_txn(input int r, input bit op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] dres,
                         output logic [31:0] data, output logic err,
                         output int rcyc, output int scyc);
    int cyc;
    req_valid    = 2'b00;
    req_valid[r] = 1'b1;
    req_op       = 2'($urandom);
    req_op[r]    = op;
    req_a = r ? {a, 32'($urandom)} : {32'($urandom), a};
    req_b = r ? {b, 32'($urandom)} : {32'($urandom), b};
    dp_result = dres;
    #1;
    chk("req_ready_winner", 32'(req_ready), 32'(2'b01 << r));
    @(posedge clk);
    #1 req_valid = 2'b00;
    cyc = 0; scyc = -1; rcyc = -1; data = '0; err = 1'b0;
    while (rcyc < 0 && cyc < TO + 20) begin
      @(negedge clk);
      cyc++;
      if (dp_start) begin
        if (scyc >= 0) chk("dp_start_single", 32'(cyc), 32'(scyc));
        scyc = cyc;
        chk("dp_a_latched", dp_a, a);
        chk("dp_b_latched", dp_b, b);
        chk("dp_op_latched", 32'(dp_op), 32'(op));
      end
      dp_done = (scyc >= 0 && lat >= 0 && cyc == scyc + lat);
      if (rsp_valid != 2'b00) begin
        rcyc = cyc;
        chk("rsp_valid_owner", 32'(rsp_valid), 32'(2'b01 << r));
        data = rsp_data;
        err  = rsp_err;
      end
    end
    dp_done = 1'b0;
    if (rcyc < 0) chk("rsp_within_bound", 32'(cyc), 32'hFFFFFFFF);
    @(negedge clk);
  endtask

  typedef struct {
    int          r;
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] dres;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] d;
    logic        e;
    int          rc, sc;
    logic [31:0] held;
    int          grants[$];
    int          guard;

    vecs[0]  = '{0, 1'b0, 32'h3F800000, 32'h40000000, 3, 32'h40400000, 32'h40400000, 1'b0, 6};
    vecs[1]  = '{1, 1'b1, 32'h7F800000, 32'h00000000, 0, 32'h0, QN, 1'b0, 2};
    vecs[2]  = '{1, 1'b0, 32'h7F800000, 32'h3F800000, 0, 32'h0, 32'h7F800000, 1'b0, 2};
    vecs[3]  = '{0, 1'b1, 32'h80000000, 32'h3F800000, 0, 32'h0, 32'h80000000, 1'b0, 2};
    vecs[4]  = '{1, 1'b0, 32'h7F800000, 32'hFF800000, 0, 32'h0, QN, 1'b0, 2};
    vecs[5]  = '{0, 1'b0, 32'h80000000, 32'h80000000, 0, 32'h0, 32'h80000000, 1'b0, 2};
    vecs[6]  = '{0, 1'b0, 32'h80000000, 32'h00000000, 0, 32'h0, 32'h00000000, 1'b0, 2};
    vecs[7]  = '{1, 1'b1, 32'hFF800000, 32'h3F800000, 0, 32'h0, 32'hFF800000, 1'b0, 2};
    vecs[8]  = '{0, 1'b0, 32'h7F800001, 32'h7F800000, 0, 32'h0, QN, 1'b0, 2};
    vecs[9]  = '{1, 1'b0, 32'h00000000, 32'h40490FDB, 0, 32'h0, 32'h40490FDB, 1'b0, 2};
    vecs[10] = '{0, 1'b1, 32'h00000001, 32'h3F800000, 1, 32'h12345678, 32'h12345678, 1'b0, 4};
    vecs[11] = '{1, 1'b0, 32'h3F800000, 32'h3F800000, TO, 32'h3F000000, 32'h3F000000, 1'b0, 3 + TO};
    vecs[12] = '{0, 1'b1, 32'h40000000, 32'h40000000, -1, 32'h0, QN, 1'b1, 3 + TO};
    vecs[13] = '{1, 1'b1, 32'h40000000, 32'h40400000, TO + 1, 32'h11111111, QN, 1'b1, 3 + TO};

    rst_n = 1'b0; req_valid = 2'b00; req_op = 2'b00;
    req_a = '0; req_b = '0; rsp_ready = 2'b11;
    dp_done = 1'b0; dp_result = '0;
    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_dp_start", 32'(dp_start), 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].lat, vecs[i].dres, d, e, rc, sc);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cycle", i), 32'(rc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_start", i), 32'(sc),
          (vecs[i].exp_cyc == 2) ? 32'hFFFFFFFF : 32'd2);
    end

    // Stray completion pulse while idle must have no effect.
    dp_done = 1'b1; dp_result = 32'hDEADBEEF;
    @(negedge clk);
    dp_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stray_done_dp_start", 32'(dp_start), 32'd0);
    end

    // Response held while requester stalls; nothing new is accepted.
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_op = 2'b00;
    req_a = {32'h0, 32'h00000000}; req_b = {32'h0, 32'h3F800000};
    @(posedge clk);
    #1 req_valid = 2'b00;
    guard = 0;
    while (rsp_valid == 2'b00 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("hold_rsp_cycle", 32'(guard), 32'd2);
    held = rsp_data;
    chk("hold_rsp_data", held, 32'h3F800000);
    req_valid = 2'b11;
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data_stable", rsp_data, held);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    @(negedge clk);
    chk("hold_release", 32'(rsp_valid), 32'd0);
    rsp_ready = 2'b11;

    // Reset during WAIT, after requester 0 was the last grant.
    req_valid = 2'b01; req_op = 2'b01;
    req_a = {32'h0, 32'h3F800000}; req_b = {32'h0, 32'h40000000};
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("pre_reset_dp_a", dp_a, 32'h3F800000);
    #2 rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_dp_start", 32'(dp_start), 32'd0);
    chk("rst_dp_op", 32'(dp_op), 32'd0);
    chk("rst_dp_a", dp_a, 32'd0);
    chk("rst_dp_b", dp_b, 32'd0);
    req_valid = 2'b00;
    #4 rst_n = 1'b1;
    @(negedge clk);
    dp_done = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);

    // Both requesters pending back-to-back: grants alternate from 0.
    req_op = 2'b11; req_a = '0; req_b = '0; req_valid = 2'b11;
    guard = 0;
    while (grants.size() < 4 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (req_ready != 2'b00)
        chk("arb_ready_onehot", 32'($onehot(req_ready)), 32'd1);
      if (rsp_valid != 2'b00) begin
        chk("arb_rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
        grants.push_back(rsp_valid[1] ? 1 : 0);
      end
    end
    req_valid = 2'b00;
    chk("arb_count", 32'(grants.size()), 32'd4);
    foreach (grants[i])
      chk($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    @(negedge clk);

    // Randomized traffic against the rule model.
    for (int k = 0; k < 40; k++) begin
      int          r, lat;
      bit          op;
      logic [31:0] a, b, dres;
      logic [32:0] m;
      r    = $urandom_range(0, 1);
      op   = 1'($urandom);
      a    = rand_opnd();
      b    = rand_opnd();
      lat  = $urandom_range(1, 6);
      dres = $urandom();
      m    = model(op, a, b);
      run_txn(r, op, a, b, lat, dres, d, e, rc, sc);
      chk($sformatf("rnd%0d_data", k), d, m[32] ? m[31:0] : dres);
      chk($sformatf("rnd%0d_err", k), 32'(e), 32'd0);
      chk($sformatf("rnd%0d_cycle", k), 32'(rc), m[32] ? 32'd2 : 32'(3 + lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_op_sched.md
Name: fpu_op_sched

Overview:
- Shares one multi-cycle FP add/mul datapath between two requesters (e.g. two issue ports) using round-robin arbitration.
- Classifies both operands before issue. IEEE-754 special cases (NaN, Inf, zero) are resolved locally without occupying the datapath.
- Sequences the datapath start/done handshake, guards it with a timeout, and returns each result to the requester that was granted.

Parameters:
- TIMEOUT_CYC, 64, max cycles in WAIT for dp_done before abort (>=2)
- CNT_W, 7, timeout counter width; must hold TIMEOUT_CYC

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; high in IDLE for the arbitration winner only
- req_op  in  2  per-requester op: 0 = add, 1 = mul
- req_a  in  64  operand A, {req1_a, req0_a}, IEEE-754 single
- req_b  in  64  operand B, {req1_b, req0_b}
- rsp_valid  out  2  result valid for requester i
- rsp_ready  in  2  requester i accepts result
- rsp_data  out  32  result word (shared; qualified by rsp_valid)
- rsp_err  out  1  1 = datapath timeout; rsp_data = 32'h7FC00000
- dp_start  out  1  one-cycle start pulse to datapath
- dp_op  out  1  latched op
- dp_a  out  32  latched operand A
- dp_b  out  32  latched operand B
- dp_done  in  1  datapath completion pulse
- dp_result  in  32  datapath result, valid with dp_done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, dp_start=0, dp_op=0, dp_a=0, dp_b=0; last_grant=1, so requester 0 wins first; timeout counter=0. Reset mid-operation abandons the transaction with no response; a late dp_done is ignored.
- FSM states: IDLE, CLASSIFY, ISSUE, WAIT, RESP.
- IDLE: if exactly one req_valid is high, that requester wins. If both are high, the requester != last_grant wins. req_ready[winner]=1 combinationally. On handshake: latch op/a/b and grant, set last_grant=grant, go to CLASSIFY.
- CLASSIFY, one cycle. Each operand is classified as NaN (exp=FF, man!=0), INF (exp=FF, man=0), ZERO (exp=0, man=0) or NORM (all else; denormals go to the datapath). The first matching rule applies:
  1. Any NaN -> 32'h7FC00000.
  2. add: INF + INF with opposite signs -> 7FC00000. INF + INF same sign, or INF + x -> the INF operand.
  3. mul: INF x ZERO -> 7FC00000. INF x x -> {sa^sb, FF, 0}.
  4. add: ZERO + ZERO -> {sa&sb, 31'b0}. ZERO + x -> x.
  5. mul: any ZERO -> {sa^sb, 31'b0}.
  6. Otherwise -> ISSUE.
  A special case loads rsp_data, sets rsp_err=0, and goes to RESP.
- ISSUE: dp_start=1 for exactly one cycle; counter cleared; go to WAIT.
- WAIT: counter increments each cycle.
  - dp_done=1 -> rsp_data=dp_result, rsp_err=0, go to RESP.
  - counter reaches TIMEOUT_CYC-1 without dp_done -> rsp_data=7FC00000, rsp_err=1, go to RESP.
  - dp_done in the same cycle as the timeout: done wins.
- RESP: rsp_valid[grant]=1; rsp_data and rsp_err are held stable until rsp_ready[grant]. On the rsp_ready cycle: rsp_valid drops, go to IDLE. No new request is accepted in that cycle (req_ready=0 outside IDLE).
- dp_done outside WAIT is ignored.
- Latency, with handshake at cycle 0:
  - Special case: rsp_valid rises at cycle 2.
  - Normal: dp_start at cycle 2; dp_done at cycle 2+L gives rsp_valid at cycle 3+L.
- One transaction in flight at a time; no pipelining.

Decomposition:
- Shared package: op codes (OP_ADD=0, OP_MUL=1); class codes (CLS_NORM=2'b00, CLS_ZERO=2'b01, CLS_INF=2'b10, CLS_NAN=2'b11); QNAN=32'h7FC00000; FSM state encoding.
- One sub-module, fpu_special_case: purely combinational. Takes op/a/b; returns is_special and result. Instantiated in CLASSIFY. The FSM, arbiter and timeout counter stay in fpu_op_sched.

Test Plan:
- Req0 add 3F800000 + 40000000, datapath model with L=3 returning 40400000 -> dp_start at cycle 2, rsp_valid[0] at cycle 6, rsp_data=40400000, rsp_err=0.
- Both requesters valid in the same IDLE cycle, back-to-back with rsp_ready tied high -> grants go 0,1,0,1; each rsp_valid goes only to its own requester.
- Req1 mul 7F800000 x 00000000 -> no dp_start; rsp_valid[1] at cycle 2, rsp_data=7FC00000. Req1 add 7F800000 + 3F800000 -> 7F800000. Mul 80000000 x 3F800000 -> 80000000.
- Datapath never asserts dp_done -> rsp_valid after TIMEOUT_CYC cycles in WAIT with rsp_err=1 and rsp_data=7FC00000. A later stray dp_done is ignored.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable; req_ready stays 0 even with req_valid=2'b11.
- rst_n pulled low during WAIT -> all outputs are 0 immediately (async); after release, the first grant goes to requester 0.
